// File: rtl/seven_sd_capture_pkg.sv
// Shared types and helpers for the seven-segment bus capture block:
// bus geometry, segment bit positions and pin-polarity normalisation.
package seven_sd_capture_pkg;

    localparam int SEG_W   = 8;
    localparam int DIGITS  = 4;
    localparam int FRAME_W = SEG_W * DIGITS;

    typedef enum int {
        SEG_A  = 0,
        SEG_B  = 1,
        SEG_C  = 2,
        SEG_D  = 3,
        SEG_E  = 4,
        SEG_F  = 5,
        SEG_G  = 6,
        SEG_DP = 7
    } seg_bit_e;

    typedef struct packed {
        logic [SEG_W-1:0]  seg;
        logic [DIGITS-1:0] en;
    } bus_sample_t;

    // After this, 1 always means lit / enabled regardless of pin wiring.
    function automatic bus_sample_t normalise_bus(
        input logic [SEG_W-1:0]  seg,
        input logic [DIGITS-1:0] en,
        input bit                seg_active_low,
        input bit                en_active_low
    );
        bus_sample_t r;
        r.seg = seg ^ {SEG_W{seg_active_low}};
        r.en  = en ^ {DIGITS{en_active_low}};
        return r;
    endfunction

    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/seven_sd_capture_if.sv
// Bus bundle between the seven-segment pins, the capture block and its
// readback consumer; the capture block sits on the slave side.
interface seven_sd_capture_if;
    import seven_sd_capture_pkg::*;

    logic [SEG_W-1:0]   segIn;
    logic [DIGITS-1:0]  enIn;
    logic [FRAME_W-1:0] valueOut;
    logic               valid;
    logic               changedPulse;
    logic               enErrPulse;
    logic               stale;

    modport master (
        output segIn,
        output enIn,
        input  valueOut,
        input  valid,
        input  changedPulse,
        input  enErrPulse,
        input  stale
    );

    modport slave (
        input  segIn,
        input  enIn,
        output valueOut,
        output valid,
        output changedPulse,
        output enErrPulse,
        output stale
    );

endinterface

// File: rtl/seven_sd_settle_sampler.sv
// Synchronises the raw segment/enable pins, normalises polarity and emits a
// single sample strobe once the pattern has been steady for SETTLE_CYCLES.
module seven_sd_settle_sampler
    import seven_sd_capture_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEG_W-1:0]  seg_i,
    input  logic [DIGITS-1:0] en_i,
    output logic              sample_o,
    output bus_sample_t       bus_o
);

    localparam int            CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][SEG_W-1:0]  seg_sync_q;
    logic [SYNC_STAGES-1:0][DIGITS-1:0] en_sync_q;
    bus_sample_t                        cur;
    bus_sample_t                        last_q;
    logic [CW-1:0]                      cnt_q;
    logic [CW-1:0]                      cnt_d;
    logic                               same;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_sync_q <= '0;
            en_sync_q  <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
        end else begin
            seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg_i};
            en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], en_i};
            last_q     <= cur;
            cnt_q      <= cnt_d;
        end
    end

    assign cur  = normalise_bus(seg_sync_q[SYNC_STAGES-1], en_sync_q[SYNC_STAGES-1],
                                SEG_ACTIVE_LOW, EN_ACTIVE_LOW);
    assign same = (cur == last_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != SETTLE_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Only the step into saturation strobes, so a long dwell samples once.
    assign sample_o = same && (cnt_q == SETTLE_LAST);
    assign bus_o    = cur;

endmodule

// File: rtl/seven_sd_capture.sv
// Passive decoder for a multiplexed seven-segment bus: rebuilds the 32-bit
// display value and publishes it once identical frames have been confirmed.
module seven_sd_capture
    import seven_sd_capture_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int CONFIRM_FRAMES = 2,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seven_sd_capture_if.slave bus
);

    localparam int            MW        = $clog2(CONFIRM_FRAMES + 1);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(CONFIRM_FRAMES);
    localparam logic [MW-1:0] MATCH_ONE = MW'(1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    logic               sample;
    bus_sample_t        smp;
    logic               capture;
    logic               en_err;

    logic [FRAME_W-1:0] cand_q,       cand_d;
    logic [FRAME_W-1:0] prev_frame_q, prev_frame_d;
    logic [FRAME_W-1:0] value_q,      value_d;
    logic [DIGITS-1:0]  seen_q,       seen_d;
    logic [MW-1:0]      match_q,      match_d;
    logic [TW-1:0]      tmo_q,        tmo_d;
    logic               valid_q,      valid_d;
    logic               stale_q,      stale_d;
    logic               changed_q,    changed_d;
    logic               enerr_q,      enerr_d;

    seven_sd_settle_sampler #(
        .SYNC_STAGES   (SYNC_STAGES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW),
        .EN_ACTIVE_LOW (EN_ACTIVE_LOW)
    ) u_sampler (
        .clk     (clk),
        .reset   (reset),
        .seg_i   (bus.segIn),
        .en_i    (bus.enIn),
        .sample_o(sample),
        .bus_o   (smp)
    );

    assign capture = sample && is_onehot(smp.en);
    assign en_err  = sample && (smp.en != '0) && !is_onehot(smp.en);

    always_comb begin
        cand_d       = cand_q;
        prev_frame_d = prev_frame_q;
        value_d      = value_q;
        seen_d       = seen_q;
        match_d      = match_q;
        tmo_d        = tmo_q;
        valid_d      = valid_q;
        stale_d      = stale_q;
        changed_d    = 1'b0;
        enerr_d      = 1'b0;

        // Overlapping enables mean the frame in flight cannot be trusted.
        if (en_err) begin
            enerr_d = 1'b1;
            seen_d  = '0;
        end

        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (smp.en[i]) begin
                    cand_d[SEG_W*i +: SEG_W] = smp.seg;
                end
            end
            seen_d  = seen_q | smp.en;
            tmo_d   = '0;
            stale_d = 1'b0;

            if (seen_d == '1) begin
                seen_d = '0;
                if (cand_d == prev_frame_q) begin
                    if (match_q != MATCH_MAX) begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    match_d = MATCH_ONE;
                end
                prev_frame_d = cand_d;

                if (match_d == MATCH_MAX) begin
                    valid_d = 1'b1;
                    if (cand_d != value_q) begin
                        value_d   = cand_d;
                        changed_d = 1'b1;
                    end
                end
            end
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
            // A silent bus invalidates confirmation history but keeps the value.
            if (tmo_d == TMO_MAX) begin
                stale_d = 1'b1;
                valid_d = 1'b0;
                match_d = '0;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q       <= '0;
            prev_frame_q <= '0;
            value_q      <= '0;
            seen_q       <= '0;
            match_q      <= '0;
            tmo_q        <= '0;
            valid_q      <= 1'b0;
            stale_q      <= 1'b0;
            changed_q    <= 1'b0;
            enerr_q      <= 1'b0;
        end else begin
            cand_q       <= cand_d;
            prev_frame_q <= prev_frame_d;
            value_q      <= value_d;
            seen_q       <= seen_d;
            match_q      <= match_d;
            tmo_q        <= tmo_d;
            valid_q      <= valid_d;
            stale_q      <= stale_d;
            changed_q    <= changed_d;
            enerr_q      <= enerr_d;
        end
    end

    assign bus.valueOut     = value_q;
    assign bus.valid        = valid_q;
    assign bus.changedPulse = changed_q;
    assign bus.enErrPulse   = enerr_q;
    assign bus.stale        = stale_q;

endmodule

// File: tb/tb_seven_sd_capture.sv
// Directed bench for seven_sd_capture: scans known display values over an
// active-low multiplexed bus and checks confirmation, errors, timeout, reset.
module tb_seven_sd_capture;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   chg_cnt;
    int   err_cnt;
    int   smp_cnt;
    int   smp_base;

    localparam logic [31:0] V1 = 32'h7FE7935C;
    localparam logic [31:0] V2 = 32'h3F065B4F;
    localparam logic [31:0] V3 = 32'h6D7D0777;
    localparam logic [31:0] V4 = 32'h5C7F3F06;
    localparam logic [31:0] V5 = 32'h5B4F6607;

    seven_sd_capture_if bus ();

    seven_sd_capture #(
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (4),
        .CONFIRM_FRAMES(2),
        .TIMEOUT_CYCLES(64),
        .SEG_ACTIVE_LOW(1'b1),
        .EN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.changedPulse === 1'b1) chg_cnt++;
        if (bus.enErrPulse === 1'b1) err_cnt++;
        if (dut.u_sampler.sample_o === 1'b1) smp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one digit (active-high byte b) for a 16-cycle dwell.
    task automatic show(input int d, input logic [7:0] b);
        logic [3:0] one;
        one       = 4'b0001;
        bus.segIn = ~b;
        bus.enIn  = ~(one << d);
        repeat (16) @(negedge clk);
    endtask

    // Same dwell, but the first 2 cycles carry the inverted byte as a glitch.
    task automatic show_glitch(input int d, input logic [7:0] b);
        logic [3:0] one;
        one       = 4'b0001;
        bus.segIn = b;
        bus.enIn  = ~(one << d);
        repeat (2) @(negedge clk);
        bus.segIn = ~b;
        repeat (14) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] v);
        for (int d = 0; d < 4; d++) show(d, v[8*d +: 8]);
    endtask

    task automatic frame_glitch(input logic [31:0] v);
        for (int d = 0; d < 4; d++) show_glitch(d, v[8*d +: 8]);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        chg_cnt = 0;
        err_cnt = 0;
        smp_cnt = 0;
        reset     = 1'b1;
        bus.segIn = 8'hFF;
        bus.enIn  = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("rst_value", bus.valueOut, 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_changed", 32'(bus.changedPulse), 32'h0);
        check("rst_enerr", 32'(bus.enErrPulse), 32'h0);
        check("rst_stale", 32'(bus.stale), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Steady scan: confirmation needs two identical frames.
        frame(V1);
        #1;
        check("t1_f1_value", bus.valueOut, 32'h0);
        check("t1_f1_valid", 32'(bus.valid), 32'h0);
        frame(V1);
        #1;
        check("t1_f2_value", bus.valueOut, V1);
        check("t1_f2_valid", 32'(bus.valid), 32'h1);
        check("t1_f2_pulses", chg_cnt, 32'd1);
        frame(V1);
        #1;
        check("t1_f3_pulses", chg_cnt, 32'd1);
        check("t1_f3_value", bus.valueOut, V1);

        // Value switches partway through a frame.
        show(0, V2[7:0]);
        show(1, V2[15:8]);
        frame(V2);
        #1;
        check("t2_hold_value", bus.valueOut, V1);
        check("t2_hold_pulses", chg_cnt, 32'd1);
        frame(V2);
        #1;
        check("t2_new_value", bus.valueOut, V2);
        check("t2_new_pulses", chg_cnt, 32'd2);
        check("t2_new_valid", 32'(bus.valid), 32'h1);

        // Short glitches at the start of every dwell must not be sampled.
        smp_base = smp_cnt;
        frame_glitch(V3);
        frame_glitch(V3);
        #1;
        check("t3_samples", smp_cnt - smp_base, 32'd8);
        check("t3_value", bus.valueOut, V3);
        check("t3_pulses", chg_cnt, 32'd3);

        // Multi-hot enable mid-frame discards the partial frame.
        show(0, V4[7:0]);
        show(1, V4[15:8]);
        bus.segIn = ~8'h55;
        bus.enIn  = ~4'b0011;
        repeat (16) @(negedge clk);
        #1;
        check("t4_enerr", err_cnt, 32'd1);
        show(2, V4[23:16]);
        show(3, V4[31:24]);
        frame(V4);
        #1;
        check("t4_delayed_value", bus.valueOut, V3);
        check("t4_delayed_pulses", chg_cnt, 32'd3);
        frame(V4);
        #1;
        check("t4_value", bus.valueOut, V4);
        check("t4_pulses", chg_cnt, 32'd4);
        check("t4_enerr_once", err_cnt, 32'd1);

        // Frozen bus: stale after 64 idle cycles, value retained.
        repeat (40) @(negedge clk);
        #1;
        check("t5_not_yet_stale", 32'(bus.stale), 32'h0);
        check("t5_not_yet_valid", 32'(bus.valid), 32'h1);
        repeat (40) @(negedge clk);
        #1;
        check("t5_stale", 32'(bus.stale), 32'h1);
        check("t5_stale_valid", 32'(bus.valid), 32'h0);
        check("t5_stale_value", bus.valueOut, V4);
        show(0, V4[7:0]);
        #1;
        check("t5_resume_stale", 32'(bus.stale), 32'h0);
        check("t5_resume_valid", 32'(bus.valid), 32'h0);
        show(1, V4[15:8]);
        show(2, V4[23:16]);
        show(3, V4[31:24]);
        #1;
        check("t5_one_frame_valid", 32'(bus.valid), 32'h0);
        frame(V4);
        #1;
        check("t5_revalid", 32'(bus.valid), 32'h1);
        check("t5_revalid_value", bus.valueOut, V4);
        check("t5_no_pulse", chg_cnt, 32'd4);

        // Reset in the middle of frame 2 clears everything at once.
        frame(V5);
        show(0, V5[7:0]);
        show(1, V5[15:8]);
        reset = 1'b1;
        #1;
        check("t6_async_value", bus.valueOut, 32'h0);
        check("t6_async_valid", 32'(bus.valid), 32'h0);
        check("t6_async_stale", 32'(bus.stale), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        frame(V5);
        #1;
        check("t6_f1_value", bus.valueOut, 32'h0);
        check("t6_f1_valid", 32'(bus.valid), 32'h0);
        frame(V5);
        #1;
        check("t6_f2_value", bus.valueOut, V5);
        check("t6_f2_valid", 32'(bus.valid), 32'h1);
        check("t6_f2_pulses", chg_cnt, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
